data_mem_lsu: RTL and testbench

//  Load/store initiator for the synchronous single-port data memory. Accepts one

---
 rtl/data_mem_lsu.sv | 187 ++++++++++++++++++
 tb/tb_data_mem_lsu.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_lsu.sv
// data_mem_lsu: single-outstanding load/store initiator for the synchronous single-port data memory.
// Optional partial-store read-modify-write is enabled by defining DATA_MEM_LSU_RMW_EN.
module data_mem_lsu #(
  parameter int unsigned ADDR_WIDTH      = 32,
  parameter int unsigned DATA_WIDTH      = 64,
  parameter int unsigned WORD_ADDR_WIDTH = 18
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_we,
  input  logic [ADDR_WIDTH-1:0]   req_addr,
  input  logic [DATA_WIDTH-1:0]   req_wdata,
  input  logic [DATA_WIDTH/8-1:0] req_be,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic                    rsp_err,
  output logic                    mem_enable,
  output logic                    mem_write_enable,
  output logic [ADDR_WIDTH-1:0]   mem_address,
  output logic [DATA_WIDTH-1:0]   mem_data_in,
  input  logic [DATA_WIDTH-1:0]   mem_data_out
);
  localparam int unsigned OFS_WIDTH = 3;

  typedef enum logic [2:0] {IDLE, ISSUE, CAPTURE, MERGE, WRITE, RESP} state_t;

  state_t                  state, state_next;
  logic                    req_ready_next, rsp_valid_next, rsp_err_next;
  logic [DATA_WIDTH-1:0]   rsp_rdata_next;
  logic                    mem_enable_next, mem_write_enable_next;
  logic [ADDR_WIDTH-1:0]   mem_address_next;
  logic [DATA_WIDTH-1:0]   mem_data_in_next;
  logic                    misaligned, out_of_range;
  logic [ADDR_WIDTH-1:0]   word_idx;

`ifdef DATA_MEM_LSU_RMW_EN
  localparam int unsigned BE_WIDTH = DATA_WIDTH / 8;
  logic                    rmw, rmw_next;
  logic [ADDR_WIDTH-1:0]   lat_addr, lat_addr_next;
  logic [DATA_WIDTH-1:0]   lat_wdata, lat_wdata_next;
  logic [BE_WIDTH-1:0]     lat_be, lat_be_next;
  logic [DATA_WIDTH-1:0]   merged;

  // Byte merge of the store data over the word read back from memory
  always_comb begin
    merged = '0;
    for (int unsigned i = 0; i < BE_WIDTH; i++) begin
      merged[i*8 +: 8] = lat_be[i] ? lat_wdata[i*8 +: 8] : mem_data_out[i*8 +: 8];
    end
  end
`endif

  // Word index is the byte address without its offset; any bit above the memory depth is an error
  assign misaligned   = (req_addr[OFS_WIDTH-1:0] != '0);
  assign out_of_range = ((req_addr >> (OFS_WIDTH + WORD_ADDR_WIDTH)) != '0);
  assign word_idx     = req_addr >> OFS_WIDTH;

  always_comb begin
    state_next            = state;
    req_ready_next        = 1'b0;
    rsp_valid_next        = rsp_valid;
    rsp_err_next          = rsp_err;
    rsp_rdata_next        = rsp_rdata;
    mem_enable_next       = 1'b0;
    mem_write_enable_next = 1'b0;
    mem_address_next      = '0;
    mem_data_in_next      = '0;
`ifdef DATA_MEM_LSU_RMW_EN
    rmw_next              = rmw;
    lat_addr_next         = lat_addr;
    lat_wdata_next        = lat_wdata;
    lat_be_next           = lat_be;
`endif
    case (state)
      IDLE: begin
        if (req_valid) begin
          rsp_rdata_next = '0;
          rsp_err_next   = 1'b0;
          if (misaligned || out_of_range) begin
            state_next     = RESP;
            rsp_valid_next = 1'b1;
            rsp_err_next   = 1'b1;
          end else if (req_we && (req_be == '0)) begin
            state_next     = RESP;
            rsp_valid_next = 1'b1;
          end else begin
            state_next       = ISSUE;
            mem_enable_next  = 1'b1;
            mem_address_next = word_idx;
`ifdef DATA_MEM_LSU_RMW_EN
            rmw_next              = req_we && (req_be != '1);
            mem_write_enable_next = req_we && (req_be == '1);
            mem_data_in_next      = (req_we && (req_be == '1)) ? req_wdata : '0;
            lat_addr_next         = word_idx;
            lat_wdata_next        = req_wdata;
            lat_be_next           = req_be;
`else
            mem_write_enable_next = req_we;
            mem_data_in_next      = req_we ? req_wdata : '0;
`endif
          end
        end
      end
      ISSUE: begin
        if (mem_write_enable) begin
          state_next     = RESP;
          rsp_valid_next = 1'b1;
`ifdef DATA_MEM_LSU_RMW_EN
        end else if (rmw) begin
          state_next = MERGE;
`endif
        end else begin
          state_next = CAPTURE;
        end
      end
      CAPTURE: begin
        state_next     = RESP;
        rsp_valid_next = 1'b1;
        rsp_rdata_next = mem_data_out;
      end
`ifdef DATA_MEM_LSU_RMW_EN
      MERGE: begin
        state_next            = WRITE;
        mem_enable_next       = 1'b1;
        mem_write_enable_next = 1'b1;
        mem_address_next      = lat_addr;
        mem_data_in_next      = merged;
      end
      WRITE: begin
        state_next     = RESP;
        rsp_valid_next = 1'b1;
      end
`endif
      RESP: begin
        if (rsp_ready) begin
          state_next     = IDLE;
          rsp_valid_next = 1'b0;
          rsp_err_next   = 1'b0;
          rsp_rdata_next = '0;
        end
      end
      default: state_next = IDLE;
    endcase
    req_ready_next = (state_next == IDLE);
  end

  // Synchronous reset aborts any access in flight and drops a pending response
  always_ff @(posedge clk) begin
    if (reset) begin
      state            <= IDLE;
      req_ready        <= 1'b1;
      rsp_valid        <= 1'b0;
      rsp_err          <= 1'b0;
      rsp_rdata        <= '0;
      mem_enable       <= 1'b0;
      mem_write_enable <= 1'b0;
      mem_address      <= '0;
      mem_data_in      <= '0;
`ifdef DATA_MEM_LSU_RMW_EN
      rmw              <= 1'b0;
      lat_addr         <= '0;
      lat_wdata        <= '0;
      lat_be           <= '0;
`endif
    end else begin
      state            <= state_next;
      req_ready        <= req_ready_next;
      rsp_valid        <= rsp_valid_next;
      rsp_err          <= rsp_err_next;
      rsp_rdata        <= rsp_rdata_next;
      mem_enable       <= mem_enable_next;
      mem_write_enable <= mem_write_enable_next;
      mem_address      <= mem_address_next;
      mem_data_in      <= mem_data_in_next;
`ifdef DATA_MEM_LSU_RMW_EN
      rmw              <= rmw_next;
      lat_addr         <= lat_addr_next;
      lat_wdata        <= lat_wdata_next;
      lat_be           <= lat_be_next;
`endif
    end
  end

endmodule

// File: tb/tb_data_mem_lsu.sv
// tb_data_mem_lsu: directed table plus randomized requests against a transaction-level model,
// with a behavioural data memory attached to the memory pins.
module tb_data_mem_lsu;
`ifdef DATA_MEM_LSU_RMW_EN
  localparam bit RMW_ON = 1'b1;
`else
  localparam bit RMW_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0, req_ready, req_we = 1'b0;
  logic [31:0] req_addr = '0;
  logic [63:0] req_wdata = '0;
  logic [7:0]  req_be = '0;
  logic        rsp_valid, rsp_ready = 1'b0, rsp_err;
  logic [63:0] rsp_rdata;
  logic        mem_enable, mem_write_enable;
  logic [31:0] mem_address;
  logic [63:0] mem_data_in, mem_data_out = '0;

  data_mem_lsu dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mem_enable(mem_enable), .mem_write_enable(mem_write_enable),
    .mem_address(mem_address), .mem_data_in(mem_data_in), .mem_data_out(mem_data_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        err;
    logic [63:0] rdata;
    int          lat;
    int          np;
    logic        p_we;
    logic [31:0] paddr;
    logic [63:0] pdata;
  } exp_t;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [63:0] wdata;
    logic [7:0]  be;
    int          hold;
    exp_t        e;
  } vec_t;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [63:0] data;
  } pulse_t;

  int checks = 0;
  int errors = 0;
  int viol = 0;
  logic prev_en = 1'b0;
  pulse_t pulses[$];
  vec_t tbl[$];
  logic [63:0] mem [logic [31:0]];
  logic [63:0] ref_mem [logic [31:0]];

  // Synchronous single-port memory: one-cycle read latency
  always @(posedge clk) begin
    if (mem_enable === 1'b1) begin
      if (mem_write_enable) mem[mem_address] = mem_data_in;
      else mem_data_out <= mem.exists(mem_address) ? mem[mem_address] : 64'h0;
    end
  end

  // Records memory pulses and flags back-to-back pulses or nonzero pins while disabled
  always @(negedge clk) begin
    if (mem_enable === 1'b1) begin
      pulses.push_back('{mem_write_enable, mem_address, mem_data_in});
      if (prev_en) viol++;
    end else if (reset === 1'b0 && (mem_enable !== 1'b0 || mem_write_enable !== 1'b0 ||
                                     mem_address !== 32'h0 || mem_data_in !== 64'h0)) begin
      viol++;
    end
    prev_en = (mem_enable === 1'b1);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level reference: outcome of one request from the address/byte-enable rules
  function automatic exp_t model(input logic we, input logic [31:0] addr,
                                 input logic [63:0] wdata, input logic [7:0] be);
    exp_t e;
    logic [31:0] w;
    logic [63:0] old, nw;
    e = '{err: 1'b0, rdata: 64'h0, lat: 1, np: 0, p_we: 1'b0, paddr: 32'h0, pdata: 64'h0};
    w = addr / 8;
    old = ref_mem.exists(w) ? ref_mem[w] : 64'h0;
    if ((addr % 8) != 0 || w >= (32'd1 << 18)) begin
      e.err = 1'b1;
    end else if (!we) begin
      e.rdata = old; e.lat = 3; e.np = 1; e.paddr = w;
    end else if (be != 8'h00) begin
      if (!RMW_ON || be == 8'hFF) begin
        nw = wdata; e.lat = 2; e.np = 1;
      end else begin
        for (int b = 0; b < 8; b++) nw[8*b +: 8] = be[b] ? wdata[8*b +: 8] : old[8*b +: 8];
        e.lat = 4; e.np = 2;
      end
      ref_mem[w] = nw;
      e.p_we = 1'b1; e.paddr = w; e.pdata = nw;
    end
    return e;
  endfunction

  task automatic add(input logic we, input logic [31:0] addr, input logic [63:0] wdata,
                     input logic [7:0] be, input int hold, input logic err, input logic [63:0] rdata,
                     input int lat, input int np, input logic p_we, input logic [31:0] paddr,
                     input logic [63:0] pdata);
    vec_t v;
    v.we = we; v.addr = addr; v.wdata = wdata; v.be = be; v.hold = hold;
    v.e = '{err: err, rdata: rdata, lat: lat, np: np, p_we: p_we, paddr: paddr, pdata: pdata};
    tbl.push_back(v);
  endtask

  task automatic run_req(input vec_t v);
    int lat;
    pulses.delete();
    @(negedge clk);
    chk("req_ready_idle", 64'(req_ready), 64'h1);
    req_valid = 1'b1; req_we = v.we; req_addr = v.addr; req_wdata = v.wdata; req_be = v.be;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_we = 1'($urandom); req_addr = $urandom; req_wdata = {$urandom, $urandom}; req_be = 8'($urandom);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (rsp_valid !== 1'b1 && lat < 20);
    chk("rsp_latency", 64'(lat), 64'(v.e.lat));
    if (rsp_valid !== 1'b1) return;
    chk("rsp_err", 64'(rsp_err), 64'(v.e.err));
    chk("rsp_rdata", rsp_rdata, v.e.rdata);
    for (int i = 0; i < v.hold; i++) begin
      @(negedge clk);
      chk("hold_valid", 64'(rsp_valid), 64'h1);
      chk("hold_rdata", rsp_rdata, v.e.rdata);
      chk("hold_err", 64'(rsp_err), 64'(v.e.err));
      chk("hold_req_ready", 64'(req_ready), 64'h0);
      chk("hold_mem_enable", 64'(mem_enable), 64'h0);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    @(negedge clk);
    chk("idle_after_rsp", {62'h0, rsp_valid, req_ready}, 64'h1);
    chk("pulse_count", 64'(pulses.size()), 64'(v.e.np));
    if (v.e.np > 0 && pulses.size() > 0) begin
      chk("pulse_we", 64'(pulses[$].we), 64'(v.e.p_we));
      chk("pulse_addr", 64'(pulses[$].addr), 64'(v.e.paddr));
      chk("pulse_data", pulses[$].data, v.e.pdata);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_req_ready"}, 64'(req_ready), 64'h1);
    chk({tag, "_rsp_valid"}, 64'(rsp_valid), 64'h0);
    chk({tag, "_rsp_err"}, 64'(rsp_err), 64'h0);
    chk({tag, "_rsp_rdata"}, rsp_rdata, 64'h0);
    chk({tag, "_mem_enable"}, 64'(mem_enable), 64'h0);
    chk({tag, "_mem_we"}, 64'(mem_write_enable), 64'h0);
    chk({tag, "_mem_address"}, 64'(mem_address), 64'h0);
    chk({tag, "_mem_data_in"}, mem_data_in, 64'h0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

  initial begin
    vec_t v;
    exp_t e;
    logic [63:0] d1;
    d1 = 64'hDEADBEEF_CAFEF00D;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    reset = 1'b0;

    // Directed vectors: {we, addr, wdata, be, hold, err, rdata, latency, pulses, last pulse we/addr/data}
    add(1, 32'h10, d1, 8'hFF, 0, 0, 64'h0, 2, 1, 1, 32'h2, d1);
    add(0, 32'h10, 64'h0, 8'h00, 0, 0, d1, 3, 1, 0, 32'h2, 64'h0);
    add(0, 32'h13, 64'h0, 8'h00, 0, 1, 64'h0, 1, 0, 0, 32'h0, 64'h0);
    add(0, 32'h0800_0000, 64'h0, 8'h00, 0, 1, 64'h0, 1, 0, 0, 32'h0, 64'h0);
    add(0, 32'h10, 64'h0, 8'h00, 5, 0, d1, 3, 1, 0, 32'h2, 64'h0);
`ifdef DATA_MEM_LSU_RMW_EN
    add(1, 32'h10, 64'h11, 8'h01, 0, 0, 64'h0, 4, 2, 1, 32'h2, 64'hDEADBEEF_CAFEF011);
    add(0, 32'h10, 64'h0, 8'h00, 0, 0, 64'hDEADBEEF_CAFEF011, 3, 1, 0, 32'h2, 64'h0);
    add(1, 32'h10, 64'h5A5A, 8'h00, 1, 0, 64'h0, 1, 0, 0, 32'h0, 64'h0);
    add(0, 32'h10, 64'h0, 8'h00, 0, 0, 64'hDEADBEEF_CAFEF011, 3, 1, 0, 32'h2, 64'h0);
`else
    add(1, 32'h10, 64'h11, 8'h01, 0, 0, 64'h0, 2, 1, 1, 32'h2, 64'h11);
    add(0, 32'h10, 64'h0, 8'h00, 0, 0, 64'h11, 3, 1, 0, 32'h2, 64'h0);
    add(1, 32'h10, 64'h5A5A, 8'h00, 1, 0, 64'h0, 1, 0, 0, 32'h0, 64'h0);
    add(0, 32'h10, 64'h0, 8'h00, 0, 0, 64'h11, 3, 1, 0, 32'h2, 64'h0);
`endif
    add(1, 32'h1C, d1, 8'hFF, 0, 1, 64'h0, 1, 0, 0, 32'h0, 64'h0);
    add(0, 32'h001F_FFF8, 64'h0, 8'h00, 0, 0, 64'h0, 3, 1, 0, 32'h3FFFF, 64'h0);
    add(0, 32'h0020_0000, 64'h0, 8'h00, 2, 1, 64'h0, 1, 0, 0, 32'h0, 64'h0);
    add(1, 32'h001F_FFF8, 64'h01234567_89ABCDEF, 8'hFF, 0, 0, 64'h0, 2, 1, 1, 32'h3FFFF, 64'h01234567_89ABCDEF);
    add(0, 32'h001F_FFF8, 64'h0, 8'h00, 0, 0, 64'h01234567_89ABCDEF, 3, 1, 0, 32'h3FFFF, 64'h0);
    for (int i = 0; i < tbl.size(); i++) run_req(tbl[i]);

    // Reset two cycles after accepting a partial store (MERGE when RMW is built in)
    mem.delete();
    ref_mem.delete();
    v = '{we: 1'b1, addr: 32'h10, wdata: d1, be: 8'hFF, hold: 0, e: model(1'b1, 32'h10, d1, 8'hFF)};
    run_req(v);
    pulses.delete();
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h10; req_wdata = 64'h11; req_be = 8'h01;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check_reset_outputs("abort");
    repeat (3) @(negedge clk);
    chk("abort_no_rsp", 64'(rsp_valid), 64'h0);
    chk("abort_pulses", 64'(pulses.size()), 64'h1);
    if (pulses.size() > 0) chk("abort_pulse_we", 64'(pulses[0].we), 64'(!RMW_ON));
    if (!RMW_ON) ref_mem[32'h2] = 64'h11;
    v = '{we: 1'b0, addr: 32'h10, wdata: 64'h0, be: 8'h00, hold: 0, e: model(1'b0, 32'h10, 64'h0, 8'h00)};
    run_req(v);

    // Randomized requests over a small working set plus error and top-of-memory addresses
    mem.delete();
    ref_mem.delete();
    for (int n = 0; n < 300; n++) begin
      int sel, bsel;
      sel = int'($urandom_range(0, 9));
      bsel = int'($urandom_range(0, 9));
      v.we = 1'($urandom);
      v.wdata = {$urandom, $urandom};
      v.be = (bsel == 0) ? 8'h00 : (bsel < 3) ? 8'hFF : 8'($urandom_range(1, 254));
      case (sel)
        0: v.addr = 32'(($urandom_range(0, 7) << 3) | $urandom_range(1, 7));
        1: v.addr = $urandom | 32'h0020_0000;
        2: v.addr = 32'h001F_FFF8;
        default: v.addr = 32'($urandom_range(0, 7) << 3);
      endcase
      v.hold = int'($urandom_range(0, 2));
      e = model(v.we, v.addr, v.wdata, v.be);
      v.e = e;
      run_req(v);
    end

    chk("protocol_violations", 64'(viol), 64'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
